disp_scan_driver: RTL and testbench

Downstream display stage for the board top: takes the CPU's 8-bit result, converts it to BCD serially (shift-and-add-3), decodes digits to 7-segment patterns, and time-multiplexes them onto the 4-digit common-cathode module on ja/jb. It replaces the free-running bin_to_bcd, seven_seg and scan logic with one synchronous block clocked by the system clock. It adds a load handshake, inter-digit dead time against ghosting, and optional leading-zero blanking.

---
 rtl/disp_scan_driver.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_disp_scan_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scan_driver
//  Purpose  : Display back end for an 8-bit result. Converts the value to
//             BCD serially (shift-and-add-3), decodes each digit to a
//             7-segment pattern and time-multiplexes three digits onto a
//             4-digit common-cathode module, with dead time between slots.
//  Ports    : clk         - system clock (single domain)
//             reset       - synchronous, active-high reset
//             value       - 8-bit unsigned value to display
//             value_valid - single-cycle load strobe for value
//             busy        - conversion running or pending
//             bcd         - committed BCD value {hundreds, tens, ones}
//             seg         - registered segments {a..g}, active-high
//             digit_n     - registered digit enables, active-low
//                           (bit0 ones, bit1 tens, bit2 hundreds, bit3 off)
//  Options  : DISP_LZB_EN - when defined, enables leading-zero blanking
//  Revision : 1.0 - initial release
// ============================================================================
module disp_scan_driver #(
    parameter int PRESCALE     = 32768,  // clocks per digit slot, 2..2^20
    parameter int BLANK_CYCLES = 64      // dead-time clocks per slot, 0..PRESCALE-1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  digit_n
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_CW         = $clog2(PRESCALE);
    localparam logic [c_CW-1:0]  c_PRESC_MAX  = c_CW'(PRESCALE - 1);
    localparam logic [c_CW-1:0]  c_BLANK_LOAD = c_CW'(BLANK_CYCLES);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    localparam logic [1:0] c_SLOT_ONES = 2'd0;
    localparam logic [1:0] c_SLOT_TENS = 2'd1;
    localparam logic [1:0] c_SLOT_HUND = 2'd2;

    localparam logic [3:0] c_LAST_STEP = 4'd7;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [3:0] f_add3(input logic [3:0] nib);
        f_add3 = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

    function automatic logic [6:0] f_decode(input logic [3:0] dig);
        logic [6:0] pat;
        case (dig)
            4'd0:    pat = 7'b1111110;
            4'd1:    pat = 7'b0110000;
            4'd2:    pat = 7'b1101101;
            4'd3:    pat = 7'b1111001;
            4'd4:    pat = 7'b0110011;
            4'd5:    pat = 7'b1011011;
            4'd6:    pat = 7'b1011111;
            4'd7:    pat = 7'b1110000;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1111011;
            default: pat = 7'b0000000;
        endcase
        f_decode = pat;
    endfunction

    // ------------------------------------------------------------------------
    // Converter signals
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [19:0] r_shift;      // {hundreds, tens, ones, binary}
    logic [3:0]  r_step;
    logic [11:0] r_bcd;
    logic        r_pend;
    logic [7:0]  r_pend_val;

    logic        w_load;
    logic        w_shift_en;
    logic        w_commit;
    logic [7:0]  w_load_val;
    logic [18:0] w_adj;

    // ------------------------------------------------------------------------
    // Converter FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Converter FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (value_valid) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (r_step == c_LAST_STEP) begin
                    w_state_nxt = c_ST_COMMIT;
                end
            end
            c_ST_COMMIT: begin
                // A strobe landing on the commit edge chains straight into
                // the next conversion, exactly like a pending value.
                if (value_valid || r_pend) begin
                    w_state_nxt = c_ST_SHIFT;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Converter FSM: outputs / datapath controls
    // ------------------------------------------------------------------------
    always_comb begin
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_commit   = 1'b0;
        w_load_val = value;
        case (r_state)
            c_ST_IDLE: begin
                w_load = value_valid;
            end
            c_ST_SHIFT: begin
                w_shift_en = 1'b1;
            end
            c_ST_COMMIT: begin
                w_commit = 1'b1;
                w_load   = value_valid || r_pend;
                // The newest strobe wins over an older pending value.
                if (!value_valid) begin
                    w_load_val = r_pend_val;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Add-3 correction ahead of each shift. The hundreds nibble is at most 1
    // before any shift of an 8-bit input, so it can never need correcting and
    // its top bit is never shifted out.
    always_comb begin
        w_adj = {r_shift[18:16], f_add3(r_shift[15:12]), f_add3(r_shift[11:8]),
                 r_shift[7:0]};
    end

    // ------------------------------------------------------------------------
    // Converter datapath, committed value and pending slot
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= 20'h00000;
            r_step     <= 4'd0;
            r_bcd      <= 12'h000;
            r_pend     <= 1'b0;
            r_pend_val <= 8'h00;
        end else begin
            if (w_load) begin
                r_shift <= {12'h000, w_load_val};
                r_step  <= 4'd0;
            end else if (w_shift_en) begin
                r_shift <= {w_adj, 1'b0};
                r_step  <= r_step + 4'd1;
            end

            if (w_commit) begin
                r_bcd <= r_shift[19:8];
            end

            // Commit always consumes the pending slot: either it is reloaded
            // from it, or a coincident strobe supersedes it.
            if (w_commit) begin
                r_pend <= 1'b0;
            end else if (value_valid && (r_state != c_ST_IDLE)) begin
                r_pend     <= 1'b1;
                r_pend_val <= value;
            end
        end
    end

    assign busy = (r_state != c_ST_IDLE) || r_pend;
    assign bcd  = r_bcd;

    // ------------------------------------------------------------------------
    // Scanner: prescaler, slot pointer, dead-time counter
    // ------------------------------------------------------------------------
    logic [c_CW-1:0] r_presc;
    logic [c_CW-1:0] r_blank;
    logic [1:0]      r_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_slot  <= c_SLOT_ONES;
            r_blank <= c_BLANK_LOAD;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_slot  <= (r_slot == c_SLOT_HUND) ? c_SLOT_ONES : (r_slot + 2'd1);
            r_blank <= c_BLANK_LOAD;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (r_blank != '0) begin
                r_blank <= r_blank - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scanner: digit select, blanking and output registers
    // ------------------------------------------------------------------------
    logic [3:0] w_digit;
    logic [2:0] w_sel;
    logic       w_lz_blank;
    logic       w_lit;
    logic [6:0] w_seg_nxt;
    logic [3:0] w_dign_nxt;

    always_comb begin
        w_digit = r_bcd[3:0];
        w_sel   = 3'b001;
        case (r_slot)
            c_SLOT_TENS: begin
                w_digit = r_bcd[7:4];
                w_sel   = 3'b010;
            end
            c_SLOT_HUND: begin
                w_digit = r_bcd[11:8];
                w_sel   = 3'b100;
            end
            default: begin
                w_digit = r_bcd[3:0];
                w_sel   = 3'b001;
            end
        endcase
    end

`ifdef DISP_LZB_EN
    // A blanked slot keeps its time slot, it is simply not lit.
    always_comb begin
        w_lz_blank = 1'b0;
        if ((r_slot == c_SLOT_HUND) && (r_bcd[11:8] == 4'd0)) begin
            w_lz_blank = 1'b1;
        end
        if ((r_slot == c_SLOT_TENS) && (r_bcd[11:4] == 8'h00)) begin
            w_lz_blank = 1'b1;
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_lit      = (r_blank == '0) && !w_lz_blank;
        w_seg_nxt  = 7'b0000000;
        w_dign_nxt = 4'b1111;
        if (w_lit) begin
            w_seg_nxt  = f_decode(w_digit);
            w_dign_nxt = {1'b1, ~w_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg     <= 7'b0000000;
            digit_n <= 4'b1111;
        end else begin
            seg     <= w_seg_nxt;
            digit_n <= w_dign_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_scan_driver
//  Purpose  : Self-checking bench for disp_scan_driver (PRESCALE=8,
//             BLANK_CYCLES=2). Conversions feed an expected-BCD queue that
//             a monitor drains as commits appear; an independent cycle model
//             predicts seg/digit_n every clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_driver;

    localparam int c_P = 8;
    localparam int c_B = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic        value_valid;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  digit_n;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [11:0] sb_q[$];
    logic [11:0] bcd_seen = 12'h000;
    logic [11:0] bcd_last = 12'h000;
    int          cyc = 0;
    int          nb;
    int          n;

    disp_scan_driver #(
        .PRESCALE     (c_P),
        .BLANK_CYCLES (c_B)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .bcd         (bcd),
        .seg         (seg),
        .digit_n     (digit_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        exp_seg = (d <= 4'd9) ? tbl[d] : 7'h00;
    endfunction

    // Scoreboard monitor: every change of bcd must be the next expected commit.
    always @(negedge clk) begin
        if (reset) begin
            bcd_seen = 12'h000;
        end else if (bcd !== bcd_seen) begin
            if (sb_q.size() > 0) begin
                check("bcd_commit", {20'h0, bcd}, {20'h0, sb_q.pop_front()});
            end else begin
                check("bcd_unexpected", {20'h0, bcd}, {20'h0, bcd_seen});
            end
            bcd_seen = bcd;
        end
    end

    // Scan model: after k clocks out of reset the outputs reflect the state
    // after k-1 clocks: position p in slot, slot index s, lit once p >= B.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        int         j, p, s;
        logic       lit;
        logic [3:0] d;
        logic [3:0] en;
        if (cyc >= 1) begin
            j   = cyc - 1;
            p   = j % c_P;
            s   = (j / c_P) % 3;
            d   = (s == 0) ? bcd_last[3:0] : (s == 1) ? bcd_last[7:4] : bcd_last[11:8];
            lit = (p >= c_B);
`ifdef DISP_LZB_EN
            if (s == 2 && bcd_last[11:8] == 4'd0) lit = 1'b0;
            if (s == 1 && bcd_last[11:4] == 8'h00) lit = 1'b0;
`endif
            en  = (s == 0) ? 4'b1110 : (s == 1) ? 4'b1101 : 4'b1011;
            check("scan", {21'h0, digit_n, seg},
                  lit ? {21'h0, en, exp_seg(d)} : {21'h0, 4'b1111, 7'h00});
        end
        bcd_last = bcd;
    end

    // Strobe v; optionally strobe v2 at loop iteration second_at. Returns the
    // number of sampled clocks busy stayed high.
    task automatic conv(input int v, input int second_at, input int v2, output int nbusy);
        @(negedge clk);
        value       = 8'(v);
        value_valid = 1'b1;
        sb_q.push_back(to_bcd(v));
        nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            value_valid = 1'b0;
            if (!busy) break;
            nbusy++;
            if (i == second_at) begin
                value       = 8'(v2);
                value_valid = 1'b1;
                sb_q.push_back(to_bcd(v2));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        value       = 8'h00;
        value_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digit_n", {28'h0, digit_n}, 32'hF);
        check("rst_seg", {25'h0, seg}, 32'h0);
        check("rst_bcd", {20'h0, bcd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;

        n = 0;
        while (digit_n == 4'hF && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_digit_n", {28'h0, digit_n}, 32'hE);
        check("first_seg", {25'h0, seg}, 32'h7E);

        conv(255, -1, 0, nb);
        check("busy_255", nb, 9);
        check("bcd_255", {20'h0, bcd}, 32'h255);
        repeat (30) @(negedge clk);

        conv(100, 2, 42, nb);
        check("busy_100_42", nb, 18);
        check("bcd_42", {20'h0, bcd}, 32'h042);
        repeat (5) @(negedge clk);

        conv(7, 8, 9, nb);
        check("busy_b2b", nb, 18);
        check("bcd_9", {20'h0, bcd}, 32'h009);
        repeat (5) @(negedge clk);

        conv(186, -1, 0, nb);
        check("busy_186", nb, 9);
        repeat (30) @(negedge clk);
        conv(36, -1, 0, nb);
        check("busy_36", nb, 9);
        repeat (30) @(negedge clk);

        conv(5, -1, 0, nb);
        check("bcd_5", {20'h0, bcd}, 32'h005);
        repeat (30) @(negedge clk);

        // Reset four shift steps into converting 200, with 42 pending.
        @(negedge clk);
        value       = 8'd200;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        @(negedge clk);
        value       = 8'd42;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_pre_rst", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_bcd", {20'h0, bcd}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_bcd", {20'h0, bcd}, 32'h0);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        check("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
